// File: rtl/axon_scan_scheduler.sv
// Per-tick axon scan sequencer: snapshots the spiking axons on tick, then walks
// them lowest index first, handing each to the synapse engine under a watchdog.
module axon_scan_scheduler #(
    parameter int NUM_AXONS = 256,
    parameter int TIMEOUT   = 1024,
    localparam int AW = $clog2(NUM_AXONS),
    localparam int WW = $clog2(TIMEOUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [NUM_AXONS-1:0] axon_spikes,
    input  logic                 scan_done,
    output logic [AW-1:0]        axon_number,
    output logic                 scan_enable,
    output logic                 busy,
    output logic                 tick_done,
    output logic [AW:0]          axons_scanned,
    output logic                 tick_overrun,
    output logic                 scan_timeout,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {IDLE, SELECT, SCAN, GAP, DONE} state_t;

    state_t               state, state_n;
    logic [NUM_AXONS-1:0] pending;
    logic [AW-1:0]        cur_axon;
    logic [WW-1:0]        wd;
    logic [AW-1:0]        sel_idx;
    logic                 sel_found;
    logic                 wd_expire;

    // Lowest set bit wins: the loop runs downward so the last hit is the smallest index.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = NUM_AXONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx   = AW'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign wd_expire = (wd == WW'(TIMEOUT - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (tick) state_n = SELECT;
            SELECT:  state_n = sel_found ? SCAN : DONE;
            SCAN:    if (scan_done || wd_expire) state_n = GAP;
            GAP:     state_n = SELECT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pending       <= '0;
            cur_axon      <= '0;
            wd            <= '0;
            axons_scanned <= '0;
            tick_overrun  <= 1'b0;
            scan_timeout  <= 1'b0;
        end else begin
            state        <= state_n;
            tick_overrun <= tick && (state != IDLE);
            case (state)
                IDLE: begin
                    if (tick) begin
                        pending       <= axon_spikes;
                        axons_scanned <= '0;
                    end
                end
                SELECT: begin
                    if (sel_found) begin
                        cur_axon <= sel_idx;
                        wd       <= '0;
                    end
                end
                SCAN: begin
                    wd <= wd + 1'b1;
                    if (scan_done || wd_expire) begin
                        pending[cur_axon] <= 1'b0;
                        axons_scanned     <= axons_scanned + 1'b1;
                    end
                    // A completion on the final watchdog cycle still counts as a clean scan.
                    if (!scan_done && wd_expire) scan_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign scan_enable = (state == SCAN);
    assign axon_number = scan_enable ? cur_axon : '0;
    assign tick_done   = (state == DONE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_axon_scan_scheduler.sv
// Scoreboard bench: instance 0 uses the default watchdog, instance 1 uses TIMEOUT=16.
// Handshake: scan_enable stays high until the engine's scan_done pulse is sampled; each
// completed scan is checked as {instance, axon, length} when scan_enable falls.
module tb_axon_scan_scheduler;

    logic         clk;
    logic         rst;
    logic [255:0] axon_spikes;
    logic [1:0]   tick;
    logic [1:0]   scan_done;
    logic [7:0]   an [2];
    logic [1:0]   se, busy, td, ov, sto;
    logic [8:0]   as [2];
    logic [2:0]   st [2];

    int checks   = 0;
    int failures = 0;

    logic [24:0] exp_scan_q[$];
    logic [9:0]  exp_done_q[$];

    int lat [2][256];
    int ecnt [2];
    int run_len [2];
    int low_len [2];
    logic [7:0] run_ax [2];
    logic [1:0] prev_se, had_scan;
    int ov_cnt [2];

    axon_scan_scheduler dut0 (
        .clk(clk), .rst(rst), .tick(tick[0]), .axon_spikes(axon_spikes),
        .scan_done(scan_done[0]), .axon_number(an[0]), .scan_enable(se[0]),
        .busy(busy[0]), .tick_done(td[0]), .axons_scanned(as[0]),
        .tick_overrun(ov[0]), .scan_timeout(sto[0]), .state_dbg(st[0])
    );

    axon_scan_scheduler #(.TIMEOUT(16)) dut1 (
        .clk(clk), .rst(rst), .tick(tick[1]), .axon_spikes(axon_spikes),
        .scan_done(scan_done[1]), .axon_number(an[1]), .scan_enable(se[1]),
        .busy(busy[1]), .tick_done(td[1]), .axons_scanned(as[1]),
        .tick_overrun(ov[1]), .scan_timeout(sto[1]), .state_dbg(st[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    endtask

    // Engine model: scan_done goes high on the lat-th cycle of a scan; lat 0 never answers.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (se[k] && !rst) begin
                ecnt[k]++;
                scan_done[k] = (lat[k][an[k]] != 0) && (ecnt[k] == lat[k][an[k]]);
            end else begin
                ecnt[k]      = 0;
                scan_done[k] = 1'b0;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                prev_se[k]  = 1'b0;
                had_scan[k] = 1'b0;
                run_len[k]  = 0;
                low_len[k]  = 0;
            end else begin
                if (se[k]) begin
                    if (!prev_se[k]) begin
                        if (had_scan[k]) chk("gap_cycles", low_len[k], 2);
                        run_ax[k]  = an[k];
                        run_len[k] = 0;
                    end
                    run_len[k]++;
                    if (an[k] != run_ax[k]) chk("axon_stable", int'(an[k]), int'(run_ax[k]));
                end else begin
                    if (busy[k]) chk("axon_number_idle", int'(an[k]), 0);
                    if (prev_se[k]) begin
                        logic [24:0] got;
                        got = {k == 1, run_ax[k], 16'(run_len[k])};
                        if (exp_scan_q.size() == 0) chk("scan_unexpected", int'(got), 0);
                        else chk("scan", int'(got), int'(exp_scan_q.pop_front()));
                        had_scan[k] = 1'b1;
                        low_len[k]  = 1;
                    end else begin
                        low_len[k]++;
                    end
                end
                if (!busy[k]) had_scan[k] = 1'b0;
                if (td[k]) begin
                    logic [9:0] gotd;
                    gotd = {k == 1, as[k]};
                    if (exp_done_q.size() == 0) chk("done_unexpected", int'(gotd), 0);
                    else chk("tick_done", int'(gotd), int'(exp_done_q.pop_front()));
                end
                if (ov[k]) ov_cnt[k]++;
                prev_se[k] = se[k];
            end
        end
    end

    // driver tasks
    task automatic do_tick(input int k);
        @(posedge clk); #1 tick[k] = 1'b1;
        @(posedge clk); #1 tick[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int limit);
        int n = 0;
        while (busy[k] && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", int'(busy[k]), 0);
    endtask

    task automatic push_scan(input int k, input int ax, input int len);
        exp_scan_q.push_back({k == 1, 8'(ax), 16'(len)});
    endtask

    task automatic push_done(input int k, input int cnt);
        exp_done_q.push_back({k == 1, 9'(cnt)});
    endtask

    initial begin
        rst = 1'b1; tick = '0; scan_done = '0; axon_spikes = '0;
        prev_se = '0; had_scan = '0;
        for (int k = 0; k < 2; k++) begin
            ecnt[k] = 0; run_len[k] = 0; low_len[k] = 0; run_ax[k] = '0; ov_cnt[k] = 0;
            for (int i = 0; i < 256; i++) lat[k][i] = 0;
        end

        // reset values and empty tick
        do_reset();
        @(negedge clk);
        chk("rst_axon_number", int'(an[0]), 0);
        chk("rst_scan_enable", int'(se[0]), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tick_done", int'(td[0]), 0);
        chk("rst_axons_scanned", int'(as[0]), 0);
        chk("rst_tick_overrun", int'(ov[0]), 0);
        chk("rst_scan_timeout", int'(sto), 0);
        push_done(0, 0);
        do_tick(0);
        @(negedge clk); chk("empty_c1_busy", int'(busy[0]), 1); chk("empty_c1_done", int'(td[0]), 0);
        @(negedge clk); chk("empty_c2_done", int'(td[0]), 1);
        @(negedge clk); chk("empty_c3_busy", int'(busy[0]), 0);

        // single axon, 257-cycle scan
        axon_spikes = '0; axon_spikes[5] = 1'b1; lat[0][5] = 257;
        push_scan(0, 5, 257); push_done(0, 1);
        do_tick(0);
        @(negedge clk); chk("single_c1_se", int'(se[0]), 0);
        @(negedge clk); chk("single_c2_se", int'(se[0]), 1); chk("single_c2_axon", int'(an[0]), 5);
        wait_idle(0, 400);
        chk("single_scanned", int'(as[0]), 1);

        // order and snapshot
        axon_spikes = '0; axon_spikes[0] = 1'b1; axon_spikes[3] = 1'b1; axon_spikes[255] = 1'b1;
        lat[0][0] = 2; lat[0][3] = 5; lat[0][255] = 3;
        push_scan(0, 0, 2); push_scan(0, 3, 5); push_scan(0, 255, 3); push_done(0, 3);
        do_tick(0);
        repeat (3) @(posedge clk);
        #1 axon_spikes = '0; axon_spikes[1] = 1'b1; axon_spikes[2] = 1'b1;
        wait_idle(0, 100);
        chk("order_scanned", int'(as[0]), 3);

        // all axons with overrun ticks
        axon_spikes = '1;
        for (int i = 0; i < 256; i++) begin
            lat[0][i] = 1;
            push_scan(0, i, 1);
        end
        push_done(0, 256);
        ov_cnt[0] = 0;
        do_tick(0);
        for (int j = 0; j < 3; j++) begin
            repeat (20) @(posedge clk);
            do_tick(0);
        end
        wait_idle(0, 2000);
        chk("overrun_pulses", ov_cnt[0], 3);
        chk("overrun_scanned", int'(as[0]), 256);

        // watchdog abort on instance 1
        do_reset();
        @(negedge clk); chk("wd_sto_clear", int'(sto[1]), 0);
        axon_spikes = '0; axon_spikes[7] = 1'b1; axon_spikes[9] = 1'b1;
        lat[1][7] = 0; lat[1][9] = 4;
        push_scan(1, 7, 16); push_scan(1, 9, 4); push_done(1, 2);
        do_tick(1);
        wait_idle(1, 200);
        chk("wd_sto_set", int'(sto[1]), 1);
        repeat (5) @(negedge clk);
        chk("wd_sto_sticky", int'(sto[1]), 1);

        // scan_done on the last watchdog cycle counts as completed
        do_reset();
        axon_spikes = '0; axon_spikes[7] = 1'b1; lat[1][7] = 16;
        push_scan(1, 7, 16); push_done(1, 1);
        do_tick(1);
        wait_idle(1, 200);
        chk("wd_edge_no_timeout", int'(sto[1]), 0);

        // reset during the scan of the second of four axons
        axon_spikes = '0;
        axon_spikes[1] = 1'b1; axon_spikes[2] = 1'b1; axon_spikes[4] = 1'b1; axon_spikes[6] = 1'b1;
        lat[1][1] = 3; lat[1][2] = 3; lat[1][4] = 3; lat[1][6] = 3;
        push_scan(1, 1, 3);
        do_tick(1);
        begin
            int n = 0;
            while (!(se[1] && an[1] == 8'd2) && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("midscan_reached", int'(se[1] && an[1] == 8'd2), 1);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midscan_idle", int'(busy[1]), 0);
        chk("midscan_scanned", int'(as[1]), 0);
        axon_spikes = '0; axon_spikes[2] = 1'b1; axon_spikes[5] = 1'b1;
        lat[1][2] = 2; lat[1][5] = 2;
        push_scan(1, 2, 2); push_scan(1, 5, 2); push_done(1, 2);
        do_tick(1);
        wait_idle(1, 100);
        chk("rescan_scanned", int'(as[1]), 2);

        // final report
        repeat (3) @(negedge clk);
        chk("scan_q_empty", exp_scan_q.size(), 0);
        chk("done_q_empty", exp_done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axon_scan_scheduler.md
# axon_scan_scheduler

Sequences the per-axon synapse scan for one core tick. On a `tick` pulse it snapshots the core's pending axon-spike vector. It then drives the synapse-connection engine one active axon at a time, lowest index first. It holds `scan_enable` until the engine reports completion, and pulses `tick_done` once every spiking axon has been scanned. A watchdog aborts any axon scan that never completes, so the core cannot hang.

## Interface
Parameters:
- `NUM_AXONS`, 256, number of axons; sets the spike-vector width and the `axon_number` width `$clog2(NUM_AXONS)`
- `TIMEOUT`, 1024, maximum cycles `scan_enable` may stay high for one axon before that scan is aborted

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset: synchronous, active-high
- `tick`  in  1  single-cycle start pulse for a core tick
- `axon_spikes`  in  NUM_AXONS  pending spike bits; sampled only on an accepted `tick`
- `scan_done`  in  1  completion pulse from the synapse-connection engine
- `axon_number`  out  $clog2(NUM_AXONS)  axon currently being scanned; valid while `scan_enable`=1, otherwise 0
- `scan_enable`  out  1  level; high for the whole of one axon scan
- `busy`  out  1  high in every state except IDLE
- `tick_done`  out  1  one-cycle pulse at the end of a tick
- `axons_scanned`  out  $clog2(NUM_AXONS)+1  number of axons scanned (completed or aborted) in the last or current tick
- `tick_overrun`  out  1  one-cycle pulse when `tick` arrives while `busy`=1
- `scan_timeout`  out  1  sticky error flag; set on any watchdog abort, cleared only by `rst`

## Operation
- State machine states: IDLE, SELECT, SCAN, GAP, DONE. All outputs are registered or decoded from the registered state.
- IDLE:
  - On `tick`=1: load `pending` <= `axon_spikes`, clear `axons_scanned`, go to SELECT.
  - Otherwise hold.
- SELECT:
  - Priority-encode the lowest set bit of `pending`.
  - If `pending`==0, go to DONE.
  - Otherwise set `cur_axon` <= that index, clear the watchdog counter, go to SCAN.
- SCAN:
  - `scan_enable`=1 and `axon_number`=`cur_axon`; the watchdog increments every cycle.
  - On `scan_done`=1: clear `pending[cur_axon]`, increment `axons_scanned`, go to GAP.
  - Otherwise, when the watchdog reaches TIMEOUT-1: set `scan_timeout`, clear `pending[cur_axon]`, increment `axons_scanned`, go to GAP.
  - `scan_done` wins over the watchdog when both occur in the same cycle.
- GAP:
  - Exactly one cycle with `scan_enable`=0, so the engine can re-arm its neuron counter.
  - Then go to SELECT.
- DONE:
  - `tick_done`=1 for this cycle only, then go to IDLE.
- `scan_done` is ignored in every state except SCAN.
- `tick` in any state other than IDLE is ignored. It pulses `tick_overrun` on the next cycle and leaves `pending` untouched.
- Changes to `axon_spikes` after the snapshot have no effect on the current tick.
- `axons_scanned` holds its value from the end of a tick until the next accepted `tick`. It never exceeds NUM_AXONS.
- Reset:
  - State goes to IDLE; `pending`, `cur_axon` and the watchdog clear.
  - All outputs go to 0, including sticky `scan_timeout`.
  - `rst` mid-tick abandons the tick with no `tick_done` pulse.

## Timing
- `tick` sampled at edge 0:
  - `busy`=1 from cycle 1 (SELECT).
  - First `scan_enable` in cycle 2.
- Per axon: SELECT (1 cycle) + SCAN (N cycles; N = cycles until `scan_done` is sampled high, N>=1) + GAP (1 cycle).
- `scan_enable` falls in the cycle after `scan_done` is sampled.
- Empty vector: `tick` at cycle 0 → SELECT in cycle 1 → `tick_done`=1 in cycle 2 → IDLE with `busy`=0 in cycle 3.
- Tick duration with K spiking axons: 2 + sum over the K axons of (N_i + 2) cycles, plus the return cycle to IDLE.
- Watchdog abort: `scan_enable` is high for exactly TIMEOUT cycles, and `scan_timeout` is set on the following edge.
- Back-to-back ticks: the earliest next accepted `tick` is in the cycle after DONE, i.e. once back in IDLE.

## Test plan
- **Reset values:** assert `rst` for 2 cycles → all outputs are 0 and `busy`=0. Pulse `tick` with `axon_spikes`=0 → `tick_done` in cycle 2, `axons_scanned`=0.
- **Single axon:** `axon_spikes` bit 5 set, engine model returns `scan_done` 257 cycles after `scan_enable` rises → `axon_number`=5 for exactly 257 cycles, `tick_done` follows, `axons_scanned`=1.
- **Order and snapshot:** bits {0, 3, 255} set, with `axon_spikes` changed mid-tick → scans run in order 0, 3, 255. Each is preceded by one SELECT cycle and followed by one GAP cycle (`scan_enable` low). `axons_scanned`=3.
- **Overrun:** all 256 bits set, plus extra `tick` pulses while `busy` → one `tick_overrun` pulse per extra tick, no restart, `axons_scanned`=256 at `tick_done`.
- **Watchdog:** TIMEOUT=16, `scan_done` never returned for axon 7 → `scan_enable` high for 16 cycles, `scan_timeout`=1 stays set, scheduler continues with the next axon. Same-cycle case: `scan_done` in cycle 16 counts as completed, with no timeout.
- **Reset mid-scan:** `rst` asserted during the SCAN of axon 2 of 4 → IDLE next cycle, no `tick_done`. A fresh `tick` rescans the new snapshot from the lowest set bit.
